// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic light conflict monitor: lamp values, fault
// causes and the monitor state machine.
package tlc_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] OFF    = 3'b000;

    localparam logic [2:0] FAULT_NONE     = 3'd0;
    localparam logic [2:0] FAULT_CONFLICT = 3'd1;
    localparam logic [2:0] FAULT_INVALID  = 3'd2;
    localparam logic [2:0] FAULT_SEQUENCE = 3'd3;
    localparam logic [2:0] FAULT_STUCK    = 3'd4;

    typedef enum logic [1:0] {
        StInit,
        StMonitor,
        StFlash
    } state_e;

endpackage

// File: rtl/light_head_check.sv
// Per-head checker: remembers the last sampled value of one light bus and flags
// encoding validity, activity and an illegal green-to-red step.
module light_head_check
    import tlc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    output logic [2:0] prev,
    output logic       valid,
    output logic       active,
    output logic       green_to_red
);

    logic [2:0] prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= RED;
        end else begin
            prev_q <= light;
        end
    end

    assign prev         = prev_q;
    assign valid        = (light == RED) || (light == YELLOW) || (light == GREEN);
    assign active       = (light == YELLOW) || (light == GREEN);
    assign green_to_red = (prev_q == GREEN) && (light == RED);

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety stage between the light controller and lamp drivers: registered
// pass-through of legal light sets, latched faults and a flashing fail-safe.
module light_conflict_monitor
    import tlc_pkg::*;
#(
    parameter int unsigned FILTER      = 2,
    parameter int unsigned STUCK_LIMIT = 32,
    parameter int unsigned FLASH_HALF  = 4,
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_S,
    input  logic       clear_fault,
    output logic [2:0] out_M1,
    output logic [2:0] out_MT,
    output logic [2:0] out_M2,
    output logic [2:0] out_S,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int unsigned FW = $clog2(FILTER + 1);
    localparam int unsigned SW = $clog2(STUCK_LIMIT + 1);
    localparam int unsigned HW = $clog2(FLASH_HALF + 1);
    localparam int unsigned IW = $clog2(INIT_CYCLES + 1);

    // Head index: 0 = M1, 1 = MT, 2 = M2, 3 = S.
    logic [3:0][2:0] lights, prevs, pass_q, pass_d, out_bus;
    logic [3:0]      valid, active, g2r;

    assign lights = {light_S, light_M2, light_MT, light_M1};

    for (genvar i = 0; i < 4; i++) begin : g_head
        light_head_check u_head (
            .clk          (clk),
            .rst          (rst),
            .light        (lights[i]),
            .prev         (prevs[i]),
            .valid        (valid[i]),
            .active       (active[i]),
            .green_to_red (g2r[i])
        );
    end

    logic conflict, invalid, cond, ok, seq_err, changed;

    assign conflict = (active[3] && (|active[2:0])) || (active[1] && active[2]);
    assign invalid  = !(&valid);
    assign cond     = conflict || invalid;
    assign ok       = !cond;
    assign seq_err  = |g2r;
    assign changed  = (lights != prevs);

    state_e        state_q, state_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [SW-1:0] stuck_q, stuck_d;
    logic [HW-1:0] flash_q, flash_d, flash_inc;
    logic [IW-1:0] init_q, init_d, init_inc;
    logic          phase_q, phase_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d;

    assign flash_inc = flash_q + 1'b1;
    assign init_inc  = init_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            filt_q  <= '0;
            stuck_q <= '0;
            flash_q <= '0;
            init_q  <= '0;
            phase_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FAULT_NONE;
            pass_q  <= {RED, RED, RED, RED};
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            stuck_q <= stuck_d;
            flash_q <= flash_d;
            init_q  <= init_d;
            phase_q <= phase_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        filt_d  = '0;
        stuck_d = '0;
        flash_d = '0;
        init_d  = '0;
        phase_d = phase_q;
        fault_d = fault_q;
        code_d  = code_q;
        pass_d  = pass_q;
        unique case (state_q)
            StInit: begin
                pass_d = {RED, RED, RED, RED};
                if (init_inc == IW'(INIT_CYCLES)) begin
                    state_d = StMonitor;
                end else begin
                    init_d = init_inc;
                end
            end
            StMonitor: begin
                if (cond) begin
                    filt_d = (filt_q == FW'(FILTER)) ? filt_q : filt_q + 1'b1;
                end
                if (!changed) begin
                    stuck_d = (stuck_q == SW'(STUCK_LIMIT)) ? stuck_q : stuck_q + 1'b1;
                end
                if (ok) begin
                    pass_d = lights;
                end
                // Lowest fault code wins when several causes coincide.
                if (cond && (filt_d == FW'(FILTER))) begin
                    code_d = conflict ? FAULT_CONFLICT : FAULT_INVALID;
                end else if (seq_err) begin
                    code_d = FAULT_SEQUENCE;
                end else if (stuck_d == SW'(STUCK_LIMIT)) begin
                    code_d = FAULT_STUCK;
                end
                if (code_d != FAULT_NONE) begin
                    state_d = StFlash;
                    fault_d = 1'b1;
                    phase_d = 1'b1;
                end
            end
            StFlash: begin
                if (clear_fault && ok) begin
                    state_d = StInit;
                    fault_d = 1'b0;
                    code_d  = FAULT_NONE;
                end else if (flash_inc == HW'(FLASH_HALF)) begin
                    phase_d = !phase_q;
                end else begin
                    flash_d = flash_inc;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        out_bus = pass_q;
        unique case (state_q)
            StInit:  out_bus = {RED, RED, RED, RED};
            StFlash: out_bus = phase_q ? {RED, YELLOW, YELLOW, YELLOW} : {OFF, OFF, OFF, OFF};
            default: out_bus = pass_q;
        endcase
    end

    assign out_M1     = out_bus[0];
    assign out_MT     = out_bus[1];
    assign out_M2     = out_bus[2];
    assign out_S      = out_bus[3];
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule
